// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: merges NCH SRAM-style request ports (req/addr_ok/data_ok)
// onto one shared memory port. It tracks up to MAX_OUT outstanding requests in
// an ID FIFO so that in-order responses are routed back to the issuing channel.
// Optional build macro: SRAM_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, the lowest channel index wins
//   undefined -> round-robin arbitration starting at rr_ptr
module sram_req_arbiter #(
    parameter int NCH     = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NCH-1:0]        ch_req,
    input  logic [NCH-1:0]        ch_wr,
    input  logic [NCH*DW/8-1:0]   ch_wstrb,
    input  logic [NCH*AW-1:0]     ch_addr,
    input  logic [NCH*DW-1:0]     ch_wdata,
    output logic [NCH-1:0]        ch_addr_ok,
    output logic [NCH-1:0]        ch_data_ok,
    output logic [DW-1:0]         ch_rdata,
    output logic                  m_req,
    output logic                  m_wr,
    output logic [DW/8-1:0]       m_wstrb,
    output logic [AW-1:0]         m_addr,
    output logic [DW-1:0]         m_wdata,
    input  logic                  m_addr_ok,
    input  logic                  m_data_ok,
    input  logic [DW-1:0]         m_rdata
);

    localparam int SW   = DW / 8;
    localparam int GW   = $clog2(NCH);
    localparam int PTRW = $clog2(MAX_OUT);
    localparam int OW   = PTRW + 1;

    logic [GW-1:0]   id_fifo [MAX_OUT];
    logic [PTRW-1:0] wr_ptr, rd_ptr;
    logic [OW-1:0]   occ;
    logic            lock;
    logic [GW-1:0]   lock_gnt;
    logic            err_unexp_q;

    logic [GW-1:0]   arb_gnt;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   head;
    logic            full;
    logic            hs;
    logic            pop;

`ifdef SRAM_ARB_FIXED_PRIO_EN
    // Fixed priority: scan downwards so the lowest requesting index is kept.
    always_comb begin
        arb_gnt = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ch_req[i]) arb_gnt = GW'(i);
        end
    end
`else
    logic [GW-1:0] rr_ptr;

    // Round-robin: first requesting channel at or after rr_ptr, wrapping.
    always_comb begin
        logic found;
        found   = 1'b0;
        arb_gnt = rr_ptr;
        for (int i = 0; i < NCH; i++) begin
            if (!found && ch_req[(int'(rr_ptr) + i) % NCH]) begin
                arb_gnt = GW'((int'(rr_ptr) + i) % NCH);
                found   = 1'b1;
            end
        end
    end

    // Priority pointer moves past the channel that just handshook.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rr_ptr <= '0;
        else if (hs)
            rr_ptr <= (grant == GW'(NCH - 1)) ? '0 : grant + 1'b1;
    end
`endif

    // A stalled request keeps its grant so the memory sees a stable payload.
    assign grant = lock ? lock_gnt : arb_gnt;
    assign full  = (occ == OW'(MAX_OUT));
    assign m_req = resetn & ((|ch_req) | lock) & ~full;
    assign hs    = m_req & m_addr_ok;
    assign pop   = resetn & m_data_ok & (occ != '0);
    assign head  = id_fifo[rd_ptr];

    // Request payload muxed from the granted channel; zero while in reset.
    always_comb begin
        m_wr    = 1'b0;
        m_wstrb = '0;
        m_addr  = '0;
        m_wdata = '0;
        if (resetn) begin
            m_wr    = ch_wr[grant];
            m_wstrb = ch_wstrb[int'(grant)*SW +: SW];
            m_addr  = ch_addr[int'(grant)*AW +: AW];
            m_wdata = ch_wdata[int'(grant)*DW +: DW];
        end
    end

    // One-hot accept to the granted channel, one-hot response to the FIFO head.
    always_comb begin
        ch_addr_ok = '0;
        ch_data_ok = '0;
        if (hs)  ch_addr_ok[grant] = 1'b1;
        if (pop) ch_data_ok[head]  = 1'b1;
    end

    assign ch_rdata = resetn ? m_rdata : '0;

    // Lock is set by an unaccepted request and cleared by the handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock     <= 1'b0;
            lock_gnt <= '0;
        end else if (hs) begin
            lock     <= 1'b0;
        end else if (m_req) begin
            lock     <= 1'b1;
            lock_gnt <= grant;
        end
    end

    // ID FIFO storage: no reset needed, validity is tracked by occ.
    always_ff @(posedge clk) begin
        if (hs) id_fifo[wr_ptr] <= grant;
    end

    // FIFO pointers and occupancy; full blocks m_req so no overflow is possible.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (hs)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({hs, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Sticky flag for a response that has no matching outstanding request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            err_unexp_q <= 1'b0;
        else if (m_data_ok && occ == '0)
            err_unexp_q <= 1'b1;
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed vectors with literal expectations plus a
// queue-based model compared against the DUT on every falling edge.
module tb_sram_req_arbiter;

    localparam int NCH = 2, AW = 32, DW = 32, MAX_OUT = 4, SW = DW / 8;

    logic clk = 1'b0, resetn = 1'b0;
    logic [NCH-1:0] ch_req, ch_wr, ch_addr_ok, ch_data_ok;
    logic [NCH*SW-1:0] ch_wstrb;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_wdata;
    logic [DW-1:0] ch_rdata, m_wdata, m_rdata;
    logic m_req, m_wr, m_addr_ok, m_data_ok;
    logic [SW-1:0] m_wstrb;
    logic [AW-1:0] m_addr;

    always #5 clk = ~clk;

    sram_req_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .resetn(resetn), .ch_req(ch_req), .ch_wr(ch_wr),
        .ch_wstrb(ch_wstrb), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_wstrb(m_wstrb), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
        .m_rdata(m_rdata)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model: list of channels awaiting a response, next preferred channel,
    // and the channel whose unaccepted request must be repeated (-1 = none).
    int q[$];
    int nxt = 0;
    int held = -1;
    bit merr = 0;

    function automatic void evaluate(output int win, output bit mreq,
                                     output logic [NCH-1:0] aok, output logic [NCH-1:0] dok);
        bit found;
        found = 0;
        win = 0;
        if (held >= 0) begin
            win = held;
            found = 1;
        end else begin
            for (int k = 0; k < NCH; k++)
                if (!found && ch_req[(nxt + k) % NCH]) begin
                    win = (nxt + k) % NCH;
                    found = 1;
                end
        end
        mreq = resetn && found && (q.size() < MAX_OUT);
        aok = '0;
        if (mreq && m_addr_ok) aok[win] = 1'b1;
        dok = '0;
        if (resetn && m_data_ok && q.size() > 0) dok[q[0]] = 1'b1;
    endfunction

    // Model state update at every clock edge, cleared by reset.
    initial forever begin
        int w; bit mr; logic [NCH-1:0] a, d;
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            q.delete(); nxt = 0; held = -1; merr = 0;
        end else begin
            evaluate(w, mr, a, d);
            if (m_data_ok && q.size() == 0) merr = 1;
            if (d != 0) void'(q.pop_front());
            if (a != 0) begin
                q.push_back(w);
`ifndef SRAM_ARB_FIXED_PRIO_EN
                nxt = (w + 1) % NCH;
`endif
                held = -1;
            end else if (mr) begin
                held = w;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        int w; bit mr; logic [NCH-1:0] a, d;
        @(negedge clk);
        evaluate(w, mr, a, d);
        chk("m_req", m_req, mr);
        chk("ch_addr_ok", ch_addr_ok, a);
        chk("ch_data_ok", ch_data_ok, d);
        chk("err_unexp_q", dut.err_unexp_q, merr);
        if (mr) begin
            chk("m_addr", m_addr, ch_addr[w*AW +: AW]);
            chk("m_wr", m_wr, ch_wr[w]);
            chk("m_wstrb", m_wstrb, ch_wstrb[w*SW +: SW]);
            chk("m_wdata", m_wdata, ch_wdata[w*DW +: DW]);
        end
        if (d != 0) chk("ch_rdata", ch_rdata, m_rdata);
    end

    task automatic tick; @(posedge clk); #1; endtask
    task automatic look; @(negedge clk); #1; endtask

    task automatic drive(input logic [NCH-1:0] req, input logic aok, input logic dok,
                         input logic [DW-1:0] rd);
        ch_req = req; m_addr_ok = aok; m_data_ok = dok; m_rdata = rd;
    endtask

    task automatic set_ch(input int c, input logic [AW-1:0] ad, input logic w,
                          input logic [SW-1:0] s, input logic [DW-1:0] d);
        ch_addr[c*AW +: AW] = ad; ch_wr[c] = w; ch_wstrb[c*SW +: SW] = s; ch_wdata[c*DW +: DW] = d;
    endtask

    logic [NCH-1:0] exp_g [4];
    logic [NCH-1:0] exp_d [4];
    logic [NCH-1:0] exp_o [4];

    initial begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_d = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_d = '{2'b10, 2'b01, 2'b10, 2'b01};
`endif
        exp_o = '{2'b01, 2'b10, 2'b10, 2'b01};
        ch_req = '0; ch_wr = '0; ch_wstrb = '0; ch_addr = '0; ch_wdata = '0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
        set_ch(0, 32'h1c000000, 0, 4'h0, 32'h0);
        set_ch(1, 32'h1c000100, 0, 4'h0, 32'h0);

        // Reset: outputs quiet even with requests and addr_ok present.
        drive(2'b11, 1, 0, 0);
        look;
        chk("rst_m_req", m_req, 0);
        chk("rst_addr_ok", ch_addr_ok, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_err", dut.err_unexp_q, 0);
        tick; tick;
        resetn = 1;

        // Single read from ch1, response three cycles later.
        drive(2'b10, 1, 0, 0);
        look;
        chk("rd_addr_ok", ch_addr_ok, 2'b10);
        chk("rd_m_addr", m_addr, 32'h1c000100);
        tick;
        drive(2'b00, 0, 0, 0);
        look; tick; look; tick;
        drive(2'b00, 0, 1, 32'hdeadbeef);
        look;
        chk("rd_data_ok", ch_data_ok, 2'b10);
        chk("rd_rdata", ch_rdata, 32'hdeadbeef);
        tick;

        // Contention until full; ch1 carries a write.
        set_ch(1, 32'h1c000200, 1, 4'hf, 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 1, 0, 0);
            look;
            chk($sformatf("cont_grant%0d", i), ch_addr_ok, exp_g[i]);
            tick;
        end
        drive(2'b11, 1, 0, 0);
        look;
        chk("full_m_req", m_req, 0);
        tick;
        drive(2'b11, 1, 1, 32'haaaa0001);
        look;
        chk("full_pop_m_req", m_req, 0);
        chk("full_pop_data_ok", ch_data_ok, 2'b01);
        tick;
        drive(2'b11, 1, 0, 0);
        look;
        chk("full_reissue_m_req", m_req, 1);
        chk("full_reissue_aok", ch_addr_ok, 2'b01);
        tick;
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 0, 1, DW'(i + 10));
            look;
            chk($sformatf("drain%0d", i), ch_data_ok, exp_d[i]);
            tick;
        end

        // Stall lock: ch0 held four cycles while ch1 joins in cycle 2.
        set_ch(0, 32'h1c000300, 0, 4'h0, 32'h0);
        set_ch(1, 32'h1c000400, 0, 4'h0, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            drive((c >= 2) ? 2'b11 : 2'b01, 0, 0, 0);
            look;
            chk($sformatf("lock_addr_c%0d", c), m_addr, 32'h1c000300);
            tick;
        end
        drive(2'b11, 1, 0, 0);
        look;
        chk("lock_hs", ch_addr_ok, 2'b01);
        tick;
        drive(2'b10, 1, 0, 0);
        look;
        chk("lock_next", ch_addr_ok, 2'b10);
        chk("lock_next_addr", m_addr, 32'h1c000400);
        tick;

        // Order: outstanding now ch0, ch1; add ch1, ch0.
        drive(2'b10, 1, 0, 0); look; tick;
        drive(2'b01, 1, 0, 0); look; tick;
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 0, 1, DW'(i + 1));
            look;
            chk($sformatf("order_dok%0d", i), ch_data_ok, exp_o[i]);
            chk($sformatf("order_rdata%0d", i), ch_rdata, DW'(i + 1));
            tick;
        end

        // Reset with two outstanding, then a stale response.
        drive(2'b01, 1, 0, 0); look; tick;
        drive(2'b10, 1, 0, 0); look; tick;
        drive(2'b00, 0, 0, 0);
        resetn = 0;
        look;
        chk("midrst_m_req", m_req, 0);
        tick;
        resetn = 1;
        drive(2'b00, 0, 1, 32'h00000bad);
        look;
        chk("unexp_data_ok", ch_data_ok, 0);
        tick;
        drive(2'b00, 0, 0, 0);
        look;
        chk("unexp_err", dut.err_unexp_q, 1);
        tick;
        drive(2'b01, 1, 0, 0);
        look;
        chk("post_rst_aok", ch_addr_ok, 2'b01);
        tick;
        drive(2'b00, 0, 1, 32'h00005a5a);
        look;
        chk("post_rst_dok", ch_data_ok, 2'b01);
        chk("post_rst_rdata", ch_rdata, 32'h00005a5a);
        tick;
        drive(2'b00, 0, 0, 0);
        look;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
